fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 32, PC and instruction-memory address width
- INSN_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset or cpu_en deassert
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock; all state updates on posedge
- reset, in, 1, asynchronous, active-low
- cpu_en, in, 1, fetch enable
- stall, in, 1, downstream ID stage not ready
- br_taken, in, 1, redirect request, sampled at posedge
- br_addr, in, ADDR_W, redirect target
- imem_req, out, 1, memory read request
- imem_addr, out, ADDR_W, memory read address
- imem_ack, in, 1, memory read complete; imem_rdata valid this cycle
- imem_rdata, in, INSN_W, read data
- if_pc, out, ADDR_W, PC of the instruction on if_insn
- if_insn, out, INSN_W, fetched instruction
- if_valid, out, 1, if_pc/if_insn hold a valid instruction

Function
REQ-003 FSM states: IDLE, REQ (request outstanding), HOLD (output occupied, fetch paused), KILL (outstanding request to be discarded).
REQ-004 Registers: fetch_pc (next address), req_addr (driven on imem_addr), if_pc, if_insn, if_valid, state.
REQ-005 Transfer = posedge with imem_req=1 and imem_ack=1; imem_rdata is ignored at all other times.
REQ-006 imem_req is combinational: 1 in KILL; 1 in REQ unless (if_valid=1 and stall=1); 0 in IDLE and HOLD.
REQ-007 Once imem_req rises, imem_addr stays constant until a transfer completes, including across branches and stalls.
REQ-008 IDLE with cpu_en=1: req_addr<=fetch_pc; go to REQ; first imem_req one cycle after reset release.
REQ-009 REQ with transfer, no branch: if_insn<=imem_rdata, if_pc<=req_addr, if_valid<=1, fetch_pc<=req_addr+4, req_addr<=req_addr+4; stay REQ if stall=0, else go to HOLD.
REQ-010 Throughput: one instruction per cycle when imem_ack is held high and stall=0.
REQ-011 if_valid clears on a posedge with if_valid=1, stall=0 and no transfer (consumed).
REQ-012 HOLD: outputs held while stall=1; when stall=0, if_valid<=0, req_addr<=fetch_pc, go to REQ.
REQ-013 Branch priority: cpu_en=0 overrides br_taken; br_taken overrides stall and transfer data.
REQ-014 br_taken=1: fetch_pc<=br_addr with bits [1:0] forced to 0; if_valid<=0; if_insn<=0.
- REQ or KILL without transfer: go to or stay in KILL.
- REQ or KILL with transfer: discard data, req_addr<=target, go to REQ.
- IDLE or HOLD: req_addr<=target, go to REQ.
REQ-015 KILL without branch: on transfer, discard data, req_addr<=fetch_pc, go to REQ.
REQ-016 cpu_en=0: fetch_pc<=RESET_PC, if_valid<=0, if_insn<=0.
- REQ without transfer: go to KILL.
- Other states, or transfer this cycle: go to IDLE.
- KILL then goes to IDLE, not REQ, after its transfer if cpu_en is still 0.
REQ-017 PC arithmetic is modulo 2^ADDR_W; fetch_pc=2^ADDR_W-4 increments to 0.

Reset
REQ-018 reset=0 asynchronously forces: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, if_pc=0, if_insn=0, if_valid=0, imem_req=0.
REQ-019 Reset mid-request abandons the transaction; the memory slave must tolerate a dropped request.

Verification
REQ-020 Reset release, cpu_en=1, ack always 1, stall=0 -> imem_addr 0,4,8,...; if_pc trails imem_addr by 1 cycle; if_valid=1 from cycle 2.
REQ-021 Ack after 3 wait cycles at addr 0x10, stall=1 on data cycle -> imem_addr held 0x10 for 3 cycles; HOLD with if_pc=0x10 until stall=0; then request 0x14.
REQ-022 br_taken with br_addr=0x103 while request to 0x20 is un-acked -> imem_addr stays 0x20 until ack; data discarded (if_valid=0); next request 0x100.
REQ-023 br_taken coincident with ack for 0x40, br_addr=0x200 -> if_valid=0; next imem_addr=0x200; if_pc never 0x40.
REQ-024 fetch_pc=0xFFFFFFFC, ADDR_W=32 -> next imem_addr=0x0.
REQ-025 cpu_en dropped during un-acked request -> KILL, ack discarded, IDLE; cpu_en re-raised -> fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-memory read channel between the fetch controller and memory.
interface fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INSN_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential reads, handles memory wait
// states, downstream stalls, branch redirects and fetch enable. A read, once
// issued, keeps its address until acknowledged; redirects that arrive while a
// read is in flight go through KILL so the stale data is dropped.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  fetch_if.master           imem,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INSN_W-1:0] if_insn,
  output logic              if_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] br_tgt;
  logic              req;
  logic              xfer;

  // Request is withheld in REQ only while a valid instruction is stalled at
  // the output, so a new one can never overwrite it.
  always_comb begin
    req    = (state == KILL) || ((state == REQ) && !(if_valid && stall));
    xfer   = req && imem.imem_ack;
    br_tgt = br_addr & ~ADDR_W'(3);
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = req_addr;

  // Fetch state machine; priority is cpu_en, then branch, then normal flow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      if_pc    <= '0;
      if_insn  <= '0;
      if_valid <= 1'b0;
    end else if (!cpu_en) begin
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_insn  <= '0;
      // An unacknowledged read must still complete before going idle.
      if ((state == REQ || state == KILL) && !xfer) state <= KILL;
      else                                          state <= IDLE;
    end else if (br_taken) begin
      fetch_pc <= br_tgt;
      if_valid <= 1'b0;
      if_insn  <= '0;
      if ((state == REQ || state == KILL) && !xfer) begin
        state <= KILL;
      end else begin
        req_addr <= br_tgt;
        state    <= REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          req_addr <= fetch_pc;
          state    <= REQ;
        end
        REQ: begin
          if (xfer) begin
            if_insn  <= imem.imem_rdata;
            if_pc    <= req_addr;
            if_valid <= 1'b1;
            fetch_pc <= req_addr + PC_INC;
            req_addr <= req_addr + PC_INC;
            state    <= stall ? HOLD : REQ;
          end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid <= 1'b0;
            req_addr <= fetch_pc;
            state    <= REQ;
          end
        end
        KILL: begin
          if (xfer) begin
            req_addr <= fetch_pc;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, wait states with stall, branches
// with and without a pending read, address wrap and fetch-enable drop.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_en = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_addr = '0;
  logic        ack = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        if_valid;
  int          checks = 0;
  int          errors = 0;

  fetch_if #(.ADDR_W(32), .INSN_W(32)) bus ();

  // Memory returns a data word derived from the address.
  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD0000;

  fetch_ctrl #(.ADDR_W(32), .INSN_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .stall(stall),
    .br_taken(br_taken), .br_addr(br_addr), .imem(bus.master),
    .if_pc(if_pc), .if_insn(if_insn), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_en = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req actual %b expected 0", bus.imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual %b expected 0", if_valid); end
    checks++; if (if_pc !== 32'h0 || if_insn !== 32'h0) begin errors++; $display("FAIL reset_out actual pc %h insn %h expected 0 0", if_pc, if_insn); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr actual %h expected 0", bus.imem_addr); end
    reset = 1'b1;
    ack   = 1'b1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL release_idle_req actual %b expected 0", bus.imem_req); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_req actual req %b addr %h expected 1 0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr%0d actual %h expected %h", i, bus.imem_addr, 32'(4 * i)); end
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_pc%0d actual v%b %h expected v1 %h", i, if_valid, if_pc, 32'(4 * (i - 1))); end
      checks++; if (if_insn !== (32'(4 * (i - 1)) ^ 32'hDEAD0000)) begin errors++; $display("FAIL stream_insn%0d actual %h expected %h", i, if_insn, 32'(4 * (i - 1)) ^ 32'hDEAD0000); end
    end
  endtask

  task automatic test_wait_stall();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin errors++; $display("FAIL wait_addr%0d actual req %b addr %h expected 1 10", i, bus.imem_req, bus.imem_addr); end
    end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL wait_consumed actual %b expected 0", if_valid); end
    ack   = 1'b1;
    stall = 1'b1;
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_insn !== 32'hDEAD0010) begin errors++; $display("FAIL hold_out actual v%b %h %h expected v1 10 dead0010", if_valid, if_pc, if_insn); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req actual %b expected 0", bus.imem_req); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_keep actual v%b %h req %b expected v1 10 req 0", if_valid, if_pc, bus.imem_req); end
    stall = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14 || if_valid !== 1'b0) begin errors++; $display("FAIL hold_exit actual req %b addr %h v%b expected 1 14 v0", bus.imem_req, bus.imem_addr, if_valid); end
  endtask

  task automatic test_branch_pending();
    step(); step(); step();
    checks++; if (bus.imem_addr !== 32'h20 || if_pc !== 32'h1C) begin errors++; $display("FAIL pre_branch actual addr %h pc %h expected 20 1c", bus.imem_addr, if_pc); end
    ack      = 1'b0;
    br_taken = 1'b1;
    br_addr  = 32'h103;
    step();
    br_taken = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20 || if_valid !== 1'b0) begin errors++; $display("FAIL kill_hold actual req %b addr %h v%b expected 1 20 v0", bus.imem_req, bus.imem_addr, if_valid); end
    step();
    checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL kill_hold2 actual %h expected 20", bus.imem_addr); end
    ack = 1'b1;
    step();
    checks++; if (bus.imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL kill_redirect actual addr %h v%b expected 100 v0", bus.imem_addr, if_valid); end
  endtask

  task automatic test_branch_ack();
    step();
    checks++; if (if_pc !== 32'h100 || if_valid !== 1'b1 || bus.imem_addr !== 32'h104) begin errors++; $display("FAIL tgt_fetch actual pc %h v%b addr %h expected 100 v1 104", if_pc, if_valid, bus.imem_addr); end
    br_taken = 1'b1;
    br_addr  = 32'h40;
    step();
    checks++; if (bus.imem_addr !== 32'h40 || if_valid !== 1'b0) begin errors++; $display("FAIL br_ack1 actual addr %h v%b expected 40 v0", bus.imem_addr, if_valid); end
    br_addr = 32'h200;
    step();
    br_taken = 1'b0;
    checks++; if (bus.imem_addr !== 32'h200 || if_valid !== 1'b0 || if_insn !== 32'h0) begin errors++; $display("FAIL br_ack2 actual addr %h v%b insn %h expected 200 v0 0", bus.imem_addr, if_valid, if_insn); end
    checks++; if (if_pc === 32'h40) begin errors++; $display("FAIL br_ack_pc actual %h expected not 40", if_pc); end
    step();
    checks++; if (if_pc !== 32'h200 || if_valid !== 1'b1 || bus.imem_addr !== 32'h204) begin errors++; $display("FAIL br_ack3 actual pc %h v%b addr %h expected 200 v1 204", if_pc, if_valid, bus.imem_addr); end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1;
    br_addr  = 32'hFFFFFFFF;
    step();
    br_taken = 1'b0;
    checks++; if (bus.imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_align actual %h expected fffffffc", bus.imem_addr); end
    step();
    checks++; if (if_pc !== 32'hFFFFFFFC || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next actual pc %h addr %h expected fffffffc 0", if_pc, bus.imem_addr); end
    step();
    checks++; if (if_pc !== 32'h0 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_cont actual pc %h addr %h expected 0 4", if_pc, bus.imem_addr); end
  endtask

  task automatic test_cpu_en();
    ack = 1'b0;
    step();
    cpu_en = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || if_valid !== 1'b0) begin errors++; $display("FAIL en_kill actual req %b addr %h v%b expected 1 4 v0", bus.imem_req, bus.imem_addr, if_valid); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL en_kill2 actual req %b addr %h expected 1 4", bus.imem_req, bus.imem_addr); end
    ack = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL en_idle actual req %b v%b expected 0 v0", bus.imem_req, if_valid); end
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL en_idle2 actual %b expected 0", bus.imem_req); end
    cpu_en = 1'b1;
    ack    = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL en_restart actual req %b addr %h expected 1 0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stall_gate();
    ack = 1'b1;
    step();
    stall = 1'b1;
    ack   = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_gate actual %b expected 0", bus.imem_req); end
    stall = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL stall_ungate actual req %b addr %h expected 1 4", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL reset_mid actual req %b addr %h v%b pc %h expected 0 0 v0 0", bus.imem_req, bus.imem_addr, if_valid, if_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_stall();
    test_branch_pending();
    test_branch_ack();
    test_wrap();
    test_cpu_en();
    test_stall_gate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
